// File: rtl/muxpga_cfg_loader.sv
// Byte-stream configuration loader and run sequencer for the muxpga fabric core.
// Bytes are split into nibbles (high first), shifted in as cmd=00, then evaluated with cmd=01.
module muxpga_cfg_loader #(
  parameter int NIBBLES = 24,
  parameter int RUN_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             start_run,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic [3:0]       run_nibble,
  input  logic             cfg_clear,
  output logic [3:0]       fab_nibble,
  output logic [1:0]       fab_cmd,
  input  logic [7:0]       fab_out,
  output logic             cfg_done,
  output logic             run_done,
  output logic [7:0]       result
);

  localparam int CNT_W = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NIBBLES);

  localparam logic [1:0] CMD_CFG  = 2'b00;
  localparam logic [1:0] CMD_EVAL = 2'b01;
  localparam logic [1:0] CMD_HOLD = 2'b10;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CONFIGURED,
    ST_RUN
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] nib_count_reg;
  logic             hi_pending_reg;
  logic [3:0]       lo_nibble_reg;
  logic [RUN_W-1:0] run_count_reg;

  // The count guard blocks a byte from being taken while the final low nibble is on the bus.
  assign s_ready = (state_reg == ST_LOAD) && !hi_pending_reg && (nib_count_reg != FULL_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_LOAD;
      nib_count_reg  <= '0;
      hi_pending_reg <= 1'b0;
      lo_nibble_reg  <= '0;
      run_count_reg  <= '0;
      fab_cmd        <= CMD_HOLD;
      fab_nibble     <= '0;
      result         <= '0;
      run_done       <= 1'b0;
      cfg_done       <= 1'b0;
    end else if (cfg_clear) begin
      state_reg      <= ST_LOAD;
      nib_count_reg  <= '0;
      hi_pending_reg <= 1'b0;
      fab_cmd        <= CMD_HOLD;
      run_done       <= 1'b0;
      cfg_done       <= 1'b0;
    end else begin
      run_done <= 1'b0;
      case (state_reg)
        ST_LOAD: begin
          if (hi_pending_reg) begin
            fab_cmd        <= CMD_CFG;
            fab_nibble     <= lo_nibble_reg;
            nib_count_reg  <= nib_count_reg + 1'b1;
            hi_pending_reg <= 1'b0;
          end else if (nib_count_reg == FULL_COUNT) begin
            state_reg <= ST_CONFIGURED;
            cfg_done  <= 1'b1;
            fab_cmd   <= CMD_HOLD;
          end else if (s_valid) begin
            fab_cmd        <= CMD_CFG;
            fab_nibble     <= s_data[7:4];
            lo_nibble_reg  <= s_data[3:0];
            nib_count_reg  <= nib_count_reg + 1'b1;
            hi_pending_reg <= 1'b1;
          end else begin
            fab_cmd <= CMD_HOLD;
          end
        end

        ST_CONFIGURED: begin
          fab_cmd <= CMD_HOLD;
          if (start_run) begin
            if (run_cycles == '0) begin
              run_done <= 1'b1;
            end else begin
              state_reg     <= ST_RUN;
              run_count_reg <= run_cycles;
              fab_cmd       <= CMD_EVAL;
              fab_nibble    <= run_nibble;
            end
          end
        end

        ST_RUN: begin
          // run_count_reg holds the evaluate cycles remaining, including the one on the bus now.
          if (run_count_reg == RUN_W'(1)) begin
            result    <= fab_out;
            run_done  <= 1'b1;
            fab_cmd   <= CMD_HOLD;
            state_reg <= ST_CONFIGURED;
          end else begin
            run_count_reg <= run_count_reg - 1'b1;
            fab_cmd       <= CMD_EVAL;
            fab_nibble    <= run_nibble;
          end
        end

        default: begin
          state_reg <= ST_LOAD;
          fab_cmd   <= CMD_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muxpga_cfg_loader.sv
// Scoreboard bench for muxpga_cfg_loader: stimulus queues expected nibbles and results,
// a negedge monitor pops and compares whenever the loader drives cmd=00/01 or pulses run_done.
module tb_muxpga_cfg_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       start_run = 1'b0;
  logic [7:0] run_cycles = '0;
  logic [3:0] run_nibble = '0;
  logic       cfg_clear = 1'b0;
  logic [3:0] fab_nibble;
  logic [1:0] fab_cmd;
  logic [7:0] fab_out;
  logic       cfg_done;
  logic       run_done;
  logic [7:0] result;

  muxpga_cfg_loader #(.NIBBLES(24), .RUN_W(8)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .start_run(start_run), .run_cycles(run_cycles), .run_nibble(run_nibble),
    .cfg_clear(cfg_clear),
    .fab_nibble(fab_nibble), .fab_cmd(fab_cmd), .fab_out(fab_out),
    .cfg_done(cfg_done), .run_done(run_done), .result(result)
  );

  always #5 clk = ~clk;

  // Fabric model: io_out counts 0x30, 0x31, ... across consecutive evaluate cycles.
  logic [7:0] eval_idx = '0;
  always @(posedge clk) begin
    if (fab_cmd == 2'b01) eval_idx <= eval_idx + 8'd1;
    else                  eval_idx <= 8'd0;
  end
  assign fab_out = 8'h30 + eval_idx;

  int checks = 0;
  int errors = 0;
  int n00 = 0;
  logic [3:0] nib_q[$];
  logic [3:0] run_q[$];
  logic [7:0] res_q[$];
  logic [7:0] exp_result = '0;
  logic       prev_cfg_done = 1'b0;
  logic [1:0] prev_cmd = 2'b10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h at %0t", name, act, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, expected none at %0t", name, $time);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      case (fab_cmd)
        2'b00: begin
          n00++;
          if (nib_q.size() == 0) flag("unexpected_cfg_cycle");
          else chk("cfg_nibble", 32'(fab_nibble), 32'(nib_q.pop_front()));
        end
        2'b01: begin
          if (run_q.size() == 0) flag("unexpected_eval_cycle");
          else chk("eval_nibble", 32'(fab_nibble), 32'(run_q.pop_front()));
        end
        2'b10: ;
        default: flag("illegal_cmd_11");
      endcase
      if (run_done) begin
        if (res_q.size() == 0) flag("unexpected_run_done");
        else chk("run_result", 32'(result), 32'(res_q.pop_front()));
      end
      if (cfg_done && !prev_cfg_done) begin
        chk("cfg_done_after_cfg_cycle", 32'(prev_cmd), 32'(2'b00));
        chk("s_ready_low_when_configured", 32'(s_ready), 32'd0);
      end
    end
    prev_cfg_done = cfg_done;
    prev_cmd = fab_cmd;
  end

  task automatic send_byte(input logic [7:0] b);
    bit taken;
    taken = 0;
    s_data = b;
    s_valid = 1'b1;
    nib_q.push_back(b[7:4]);
    nib_q.push_back(b[3:0]);
    for (int k = 0; k < 50 && !taken; k++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        taken = 1;
      end
    end
    if (!taken) flag("byte_not_accepted_timeout");
  endtask

  task automatic wait_cfg_done(input int c0);
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (cfg_done) seen = 1;
    end
    if (!seen) flag("cfg_done_timeout");
    chk("cfg_cycle_count", 32'(n00 - c0), 32'd24);
    chk("nib_queue_drained", 32'(nib_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_full(input int gap_after);
    int c0;
    c0 = n00;
    for (int i = 1; i <= 12; i++) begin
      send_byte(8'(i));
      if (i == gap_after) begin
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0;
    wait_cfg_done(c0);
  endtask

  task automatic do_run(input int n, input logic [3:0] nib);
    for (int i = 0; i < n; i++) run_q.push_back(nib);
    if (n > 0) exp_result = 8'h30 + 8'(n - 1);
    res_q.push_back(exp_result);
    start_run = 1'b1;
    run_cycles = 8'(n);
    run_nibble = nib;
    @(posedge clk);
    #1;
    start_run = 1'b0;
    repeat (n + 3) @(posedge clk);
    #1;
    chk("run_queue_drained", 32'(run_q.size()), 32'd0);
    chk("result_queue_drained", 32'(res_q.size()), 32'd0);
    chk("cmd_hold_after_run", 32'(fab_cmd), 32'(2'b10));
    chk("result_held", 32'(result), 32'(exp_result));
  endtask

  task automatic pulse_clear();
    cfg_clear = 1'b1;
    @(posedge clk);
    #1;
    cfg_clear = 1'b0;
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    chk("rst_fab_cmd", 32'(fab_cmd), 32'(2'b10));
    chk("rst_fab_nibble", 32'(fab_nibble), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_run_done", 32'(run_done), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("s_ready_after_reset", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back load, then clear and reload with a 3-cycle gap after byte 4
    load_full(0);
    pulse_clear();
    @(negedge clk);
    chk("cfg_done_cleared", 32'(cfg_done), 32'd0);
    @(posedge clk);
    #1;
    load_full(4);

    // Runs: 3 cycles, then zero cycles
    do_run(3, 4'hA);
    do_run(0, 4'h7);

    // Abort a 5-cycle run in its second evaluate cycle
    run_q.push_back(4'h5);
    run_q.push_back(4'h5);
    start_run = 1'b1;
    run_cycles = 8'd5;
    run_nibble = 4'h5;
    @(posedge clk);
    #1;
    start_run = 1'b0;
    @(posedge clk);
    #1;
    cfg_clear = 1'b1;
    @(posedge clk);
    #1;
    cfg_clear = 1'b0;
    @(negedge clk);
    chk("abort_cmd_hold", 32'(fab_cmd), 32'(2'b10));
    chk("abort_cfg_done", 32'(cfg_done), 32'd0);
    chk("abort_s_ready", 32'(s_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_run_queue_drained", 32'(run_q.size()), 32'd0);
    chk("abort_result_kept", 32'(result), 32'(exp_result));
    load_full(0);

    // Reset after 7 bytes of a fresh load
    pulse_clear();
    for (int i = 1; i <= 7; i++) send_byte(8'(8'h10 + i));
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("partial_nibbles_drained", 32'(nib_q.size()), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_values();
    exp_result = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    load_full(0);

    chk("final_nib_queue", 32'(nib_q.size()), 32'd0);
    chk("final_res_queue", 32'(res_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
